// File: rtl/call_stack.sv
// Return-address stack for the PIC16C5x core: pushes the PC on CALL, pops on RETLW.
// Optional sticky overflow/underflow status flags are built when CALL_STACK_STATUS_EN is defined.

`ifndef EX_STATE_BITS
  `define EX_STATE_BITS 5
  `define PC_WIDTH      11
  `define EX_Q1         5'd0
  `define EX_Q2         5'd1
  `define EX_Q3         5'd2
  `define EX_Q4_NOP     5'd3
  `define EX_Q4_GOTO    5'd4
  `define EX_Q4_CALL    5'd5
  `define EX_Q4_RETLW   5'd6
`endif

module call_stack #(
  parameter int STACK_DEPTH = 2,
  parameter int LVL_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [`EX_STATE_BITS-1:0] executeState,
  input  logic [`PC_WIDTH-1:0]      pcIn,
  output logic [`PC_WIDTH-1:0]      stackOut,
  output logic [LVL_WIDTH-1:0]      level,
  output logic                      overflow,
  output logic                      underflow
);

  logic [`PC_WIDTH-1:0] stk [STACK_DEPTH];
  logic                 push;
  logic                 pop;
  logic                 isFull;
  logic                 isEmpty;

  // Push and pop decode from a single state value, so they can never both be high.
  assign push    = (executeState == `EX_Q4_CALL);
  assign pop     = (executeState == `EX_Q4_RETLW);
  assign isFull  = (level == LVL_WIDTH'(STACK_DEPTH));
  assign isEmpty = (level == '0);

  // Registered view only: the PC block samples this on the RETLW edge.
  assign stackOut = stk[0];

  // NOTE: the stack is only a few flops deep, so every entry gets the async reset;
  // a large RAM-style array would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk[i] <= '0;
      end
    end else if (push) begin
      // NOTE: non-blocking assignments make every entry read its neighbour's old value,
      // so the loop order does not matter and the shift is a true parallel move.
      for (int i = STACK_DEPTH - 1; i >= 1; i--) begin
        stk[i] <= stk[i-1];
      end
      stk[0] <= pcIn;
    end else if (pop) begin
      // The bottom entry is retained, duplicating upward as on silicon.
      for (int i = 0; i < STACK_DEPTH - 1; i++) begin
        stk[i] <= stk[i+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (push && !isFull) begin
      level <= level + LVL_WIDTH'(1);
    end else if (pop && !isEmpty) begin
      level <= level - LVL_WIDTH'(1);
    end
  end

`ifdef CALL_STACK_STATUS_EN
  logic overflowQ;
  logic underflowQ;

  // Sticky debug flags; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      if (push && isFull)  overflowQ  <= 1'b1;
      if (pop  && isEmpty) underflowQ <= 1'b1;
    end
  end

  assign overflow  = overflowQ;
  assign underflow = underflowQ;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
